// File: rtl/osd_pkg.sv
// ============================================================================
// Module : osd_pkg
// Brief  : Shared constants, fetch FSM state encoding and font address helper
//          for the OSD font sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package osd_pkg;

  localparam int OSD_X1_DEF = 48;
  localparam int OSD_Y1_DEF = 40;
  localparam int CHAR_H_DEF = 12;
  localparam int GLYPH_W    = 8;
  localparam int FONT_AW    = 12;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE    = 2'd0;
  localparam fetch_state_t ST_CHAR_RD = 2'd1;
  localparam fetch_state_t ST_FONT_RD = 2'd2;
  localparam fetch_state_t ST_LOAD    = 2'd3;

  // Result deliberately wraps at FONT_AW bits.
  function automatic logic [FONT_AW-1:0] calc_font_addr(
    input logic [7:0] code,
    input logic [7:0] line,
    input int         char_h
  );
    return FONT_AW'(code) * FONT_AW'(char_h) + FONT_AW'(line);
  endfunction

endpackage

`default_nettype wire

// File: rtl/osd_glyph_shifter.sv
// ============================================================================
// Module : osd_glyph_shifter
// Brief  : Per-dot glyph shift register with horizontal bit stretching and
//          registered pixel/window outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module osd_glyph_shifter
  import osd_pkg::*;
#(
  parameter int HSCALE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_pix_en,
  input  logic               i_vblank,
  input  logic               i_win_dot,
  input  logic               i_boundary,
  input  logic [GLYPH_W-1:0] i_next_glyph,
  input  logic               i_next_valid,
  input  logic               i_next_inv,
  output logic               o_pix,
  output logic               o_win
);

  logic [GLYPH_W-1:0] shift_q, shift_d;
  logic               bit_tick_q, bit_tick_d;
  logic               pix_q, pix_d;
  logic               win_q, win_d;

  always_comb begin
    shift_d    = shift_q;
    bit_tick_d = bit_tick_q;
    pix_d      = pix_q;
    win_d      = win_q;
    if (i_vblank) begin
      pix_d = 1'b0;
      win_d = 1'b0;
    end else if (i_pix_en) begin
      if (i_win_dot) begin
        if (i_boundary) begin
          // A missing prefetch shows as a blank cell rather than stale data.
          shift_d    = i_next_valid ? (i_next_glyph ^ {GLYPH_W{i_next_inv}}) : '0;
          bit_tick_d = 1'b0;
        end else if (bit_tick_q == 1'(HSCALE - 1)) begin
          bit_tick_d = 1'b0;
          shift_d    = {shift_q[GLYPH_W-2:0], 1'b0};
        end else begin
          bit_tick_d = bit_tick_q + 1'b1;
        end
        pix_d = shift_d[GLYPH_W-1];
        win_d = 1'b1;
      end else begin
        pix_d = 1'b0;
        win_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_tick_q <= 1'b0;
      pix_q      <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_tick_q <= bit_tick_d;
      pix_q      <= pix_d;
      win_q      <= win_d;
    end
  end

  assign o_pix = pix_q;
  assign o_win = win_q;

endmodule

`default_nettype wire

// File: rtl/osd_font_sequencer.sv
// ============================================================================
// Module : osd_font_sequencer
// Brief  : Fetches character codes and glyph rows one cell ahead and streams
//          one glyph bit per OSD window dot.
// Build  : define OSD_INVERT_EN to show codes with bit 7 set inverted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module osd_font_sequencer
  import osd_pkg::*;
#(
  parameter int OSD_X1  = OSD_X1_DEF,
  parameter int OSD_Y1  = OSD_Y1_DEF,
  parameter int COLS    = 16,
  parameter int ROWS    = 4,
  parameter int CHAR_H  = CHAR_H_DEF,
  parameter int HSCALE  = 2,
  parameter int CADDR_W = 6
) (
  input  logic               CLK_i,
  input  logic               NRST_i,
  input  logic               PIX_EN_i,
  input  logic [9:0]         HCNT_i,
  input  logic [8:0]         VCNT_i,
  input  logic               VBLANK_i,
  input  logic               OSD_EN_i,
  output logic [CADDR_W-1:0] CHAR_ADDR_o,
  input  logic [7:0]         CHAR_DATA_i,
  output logic [FONT_AW-1:0] FONT_ADDR_o,
  input  logic [7:0]         FONT_DATA_i,
  output logic               OSD_PIX_o,
  output logic               OSD_WIN_o
);

  localparam int CELL_W = GLYPH_W * HSCALE;
  localparam int COL_W  = $clog2(COLS + 1);
  localparam int ROW_W  = $clog2(ROWS + 1);
  localparam int GL_W   = $clog2(CHAR_H + 1);
  localparam int WIN_X2 = OSD_X1 + COLS * CELL_W;
  localparam int WIN_Y2 = OSD_Y1 + ROWS * CHAR_H;

  fetch_state_t       state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [GL_W-1:0]    glyph_line_q, glyph_line_d;
  logic [ROW_W-1:0]   text_row_q, text_row_d;
  logic               osd_on_q, osd_on_d;
  logic               line_in_win_q, line_in_win_d;
  logic               fetch_act_q, fetch_act_d;
  logic               fetch_req_q, fetch_req_d;
  logic               next_valid_q, next_valid_d;
  logic [GLYPH_W-1:0] next_glyph_q, next_glyph_d;
  logic               next_inv_q, next_inv_d;
  logic [7:0]         code_q, code_d;

  logic       w_line_tick, w_line_in, w_win_dot, w_boundary;
  logic       w_prefetch, w_consume, w_auto, w_inv_flag;
  logic [7:0] w_code, w_code_idx;

  assign w_line_tick = PIX_EN_i && (HCNT_i == 10'd0);
  assign w_line_in   = (VCNT_i >= 9'(OSD_Y1)) && (VCNT_i < 9'(WIN_Y2));
  assign w_win_dot   = osd_on_q && line_in_win_q &&
                       (HCNT_i >= 10'(OSD_X1)) && (HCNT_i < 10'(WIN_X2));
  assign w_boundary  = ((HCNT_i - 10'(OSD_X1)) & 10'(CELL_W - 1)) == 10'd0;
  assign w_prefetch  = PIX_EN_i && !VBLANK_i && osd_on_q && line_in_win_q &&
                       (HCNT_i == 10'(OSD_X1 - 1));
  assign w_consume   = PIX_EN_i && !VBLANK_i && w_win_dot && w_boundary;
  assign w_auto      = fetch_act_q && !next_valid_q && (col_q < COL_W'(COLS));

  // During FONT_RD the RAM data is forwarded so the ROM sees its address in time.
  assign w_code = (state_q == ST_FONT_RD) ? CHAR_DATA_i : code_q;

`ifdef OSD_INVERT_EN
  assign w_code_idx = w_code & 8'h7F;
  assign w_inv_flag = code_q[7];
`else
  assign w_code_idx = w_code;
  assign w_inv_flag = 1'b0;
`endif

  assign CHAR_ADDR_o = CADDR_W'(32'(text_row_q) * 32'(COLS) + 32'(col_q));
  assign FONT_ADDR_o = calc_font_addr(w_code_idx, 8'(glyph_line_q), CHAR_H);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    glyph_line_d  = glyph_line_q;
    text_row_d    = text_row_q;
    osd_on_d      = osd_on_q;
    line_in_win_d = line_in_win_q;
    fetch_act_d   = fetch_act_q;
    fetch_req_d   = fetch_req_q | w_prefetch;
    next_valid_d  = next_valid_q;
    next_glyph_d  = next_glyph_q;
    next_inv_d    = next_inv_q;
    code_d        = code_q;

    if (VBLANK_i) begin
      osd_on_d      = OSD_EN_i;
      glyph_line_d  = '0;
      text_row_d    = '0;
      line_in_win_d = 1'b0;
      fetch_act_d   = 1'b0;
      fetch_req_d   = 1'b0;
    end else if (w_line_tick) begin
      // The previous line's window status decides whether the glyph line advances.
      line_in_win_d = w_line_in;
      fetch_act_d   = 1'b0;
      if (line_in_win_q) begin
        if (glyph_line_q == GL_W'(CHAR_H - 1)) begin
          glyph_line_d = '0;
          text_row_d   = text_row_q + ROW_W'(1);
        end else begin
          glyph_line_d = glyph_line_q + GL_W'(1);
        end
      end
    end

    if (w_prefetch) begin
      col_d        = '0;
      next_valid_d = 1'b0;
      fetch_act_d  = 1'b1;
    end
    if (w_consume) begin
      next_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!VBLANK_i && (w_prefetch || fetch_req_q || w_auto)) begin
          state_d     = ST_CHAR_RD;
          fetch_req_d = 1'b0;
        end
      end
      ST_CHAR_RD: state_d = VBLANK_i ? ST_IDLE : ST_FONT_RD;
      ST_FONT_RD: begin
        code_d  = CHAR_DATA_i;
        state_d = VBLANK_i ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        // A line restart during this fetch makes its result stale; drop it.
        if (!fetch_req_q && !w_prefetch) begin
          next_glyph_d = FONT_DATA_i;
          next_inv_d   = w_inv_flag;
          next_valid_d = 1'b1;
          col_d        = col_q + COL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      glyph_line_q  <= '0;
      text_row_q    <= '0;
      osd_on_q      <= 1'b0;
      line_in_win_q <= 1'b0;
      fetch_act_q   <= 1'b0;
      fetch_req_q   <= 1'b0;
      next_valid_q  <= 1'b0;
      next_glyph_q  <= '0;
      next_inv_q    <= 1'b0;
      code_q        <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      glyph_line_q  <= glyph_line_d;
      text_row_q    <= text_row_d;
      osd_on_q      <= osd_on_d;
      line_in_win_q <= line_in_win_d;
      fetch_act_q   <= fetch_act_d;
      fetch_req_q   <= fetch_req_d;
      next_valid_q  <= next_valid_d;
      next_glyph_q  <= next_glyph_d;
      next_inv_q    <= next_inv_d;
      code_q        <= code_d;
    end
  end

  osd_glyph_shifter #(
    .HSCALE (HSCALE)
  ) u_shifter (
    .clk          (CLK_i),
    .rst_n        (NRST_i),
    .i_pix_en     (PIX_EN_i),
    .i_vblank     (VBLANK_i),
    .i_win_dot    (w_win_dot),
    .i_boundary   (w_boundary),
    .i_next_glyph (next_glyph_q),
    .i_next_valid (next_valid_q),
    .i_next_inv   (next_inv_q),
    .o_pix        (OSD_PIX_o),
    .o_win        (OSD_WIN_o)
  );

endmodule

`default_nettype wire
